// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// counter action type and the shift-counter width helper.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_SET  = 3'b111;

  typedef enum logic [1:0] {
    CNT_KEEP = 2'b00,
    CNT_INC  = 2'b01,
    CNT_CLR  = 2'b10
  } cnt_op_e;

  // Enough bits to hold a count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with hold, shift, rotate, load, clear
// and set modes, plus a saturating count of bits shifted since the last
// load/clear/set.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [2:0]                    mode,
  input  logic [WIDTH-1:0]              d,
  input  logic                          sin_r,
  input  logic                          sin_l,
  output logic [WIDTH-1:0]              q,
  output logic [WIDTH-1:0]              qn,
  output logic                          sout_r,
  output logic                          sout_l,
  output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
  output logic                          empty
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  cnt_op_e          cnt_op;

  // Decode the mode into the next register value and a counter action.
  // Anything not matching a known code (including X) behaves as HOLD.
  always_comb begin
    q_nxt  = q;
    cnt_op = CNT_KEEP;
    case (mode)
      MODE_SHR: begin
        q_nxt  = {sin_r, q[WIDTH-1:1]};
        cnt_op = CNT_INC;
      end
      MODE_SHL: begin
        q_nxt  = {q[WIDTH-2:0], sin_l};
        cnt_op = CNT_INC;
      end
      MODE_LOAD: begin
        q_nxt  = d;
        cnt_op = CNT_CLR;
      end
      MODE_ROR: begin
        q_nxt  = {q[0], q[WIDTH-1:1]};
        cnt_op = CNT_INC;
      end
      MODE_ROL: begin
        q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
        cnt_op = CNT_INC;
      end
      MODE_CLR: begin
        q_nxt  = '0;
        cnt_op = CNT_CLR;
      end
      MODE_SET: begin
        q_nxt  = '1;
        cnt_op = CNT_CLR;
      end
      default: begin
        q_nxt  = q;
        cnt_op = CNT_KEEP;
      end
    endcase
  end

  // Data register: async reset to RST_VAL, update only when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= q_nxt;
    end
  end

  // Shift counter: rotates count as shifts; saturates at WIDTH, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= '0;
    end else if (en) begin
      case (cnt_op)
        CNT_CLR: shift_cnt <= '0;
        CNT_INC: if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + CW'(1);
        default: shift_cnt <= shift_cnt;
      endcase
    end
  end

  // Derived outputs are purely combinational from q and the count.
  always_comb begin
    qn     = ~q;
    sout_r = q[0];
    sout_l = q[WIDTH-1];
    empty  = (shift_cnt == CNT_MAX);
  end

  // An unknown mode while enabled silently holds; make that visible in sim.
  a_mode_known: assert property (@(posedge clk) disable iff (!rst)
                                 en |-> !$isunknown(mode));

endmodule
